// File: rtl/seg_scan_controller_pkg.sv
// rtl/seg_scan_controller_pkg.sv - shared types and constants for the scanned seven-segment display
package display_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_COMMIT  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] BCD_BLANK = 4'hF;

   function automatic logic [31:0] pow10(input int n);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < n; i++) r = r * 32'd10;
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// rtl/seg_scan_controller_if.sv - load/status and display pin bundle for seg_scan_controller
interface seg_scan_controller_if #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
);
   logic [BIN_W-1:0]  i_Value;
   logic              i_Load;
   logic              o_Busy;
   logic              o_Overflow;
   logic [6:0]        o_Segment;
   logic [DIGITS-1:0] o_Digit_En;

   modport master (output i_Value, i_Load,
                   input  o_Busy, o_Overflow, o_Segment, o_Digit_En);
   modport slave  (input  i_Value, i_Load,
                   output o_Busy, o_Overflow, o_Segment, o_Digit_En);
endinterface

// File: rtl/seg_scan_controller_bcd_shift_converter.sv
// rtl/seg_scan_controller_bcd_shift_converter.sv - sequential shift-add-3 binary to BCD converter
module bcd_shift_converter #(
   parameter int BIN_W  = 7,
   parameter int DIGITS = 2
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_n,
   input  logic                  i_Start,
   input  logic [BIN_W-1:0]      i_Value,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic [4*DIGITS-1:0]   o_Bcd
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0]       bin_q;
   logic [BCD_W-1:0]       bcd_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   busy_q;
   logic [BCD_W-1:0]       adj;
   logic [BCD_W+BIN_W-1:0] sh;

   always_comb begin
      adj = bcd_q;
      for (int k = 0; k < DIGITS; k++)
         if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      sh = {adj, bin_q} << 1;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (i_Start) begin
         bin_q  <= i_Value;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         {bcd_q, bin_q} <= sh;
         cnt_q <= cnt_q + 1'b1;
         if (cnt_q == CNT_W'(BIN_W - 1)) busy_q <= 1'b0;
      end
   end

   // Done marks the cycle performing the final shift; o_Bcd is final on the next cycle.
   assign o_Done = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
   assign o_Busy = busy_q;
   assign o_Bcd  = bcd_q;
endmodule

// File: rtl/seg_scan_controller_segment_display.sv
// rtl/seg_scan_controller_segment_display.sv - BCD digit to active-low segments {g,f,e,d,c,b,a}
module SegmentDisplay (
   input  logic [3:0] i_Binary_Num,
   output logic [6:0] o_Segment
);
   always_comb begin
      case (i_Binary_Num)
         4'd0:    o_Segment = 7'b1000000;
         4'd1:    o_Segment = 7'b1111001;
         4'd2:    o_Segment = 7'b0100100;
         4'd3:    o_Segment = 7'b0110000;
         4'd4:    o_Segment = 7'b0011001;
         4'd5:    o_Segment = 7'b0010010;
         4'd6:    o_Segment = 7'b0000010;
         4'd7:    o_Segment = 7'b1111000;
         4'd8:    o_Segment = 7'b0000000;
         4'd9:    o_Segment = 7'b0010000;
         default: o_Segment = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - binary load, BCD conversion and multiplexed digit scan for a seven-segment display
module seg_scan_controller
   import display_pkg::*;
#(
   parameter int DIGITS        = 2,
   parameter int BIN_W         = 7,
   parameter int SCAN_DIV      = 25000,
   parameter int BLANK_LEADING = 1
) (
   input  logic i_Clk,
   input  logic i_Rst_n,
   seg_scan_controller_if.slave bus
);
   localparam int BCD_W   = 4 * DIGITS;
   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PRESC_W = $clog2(SCAN_DIV);

   state_t              state_q, state_d;
   logic                conv_start, conv_done, conv_busy, commit;
   logic [BCD_W-1:0]    conv_bcd;
   logic [BCD_W-1:0]    disp_q;
   logic                ovf_pend_q, ovf_q;
   logic [PRESC_W-1:0]  presc_q;
   logic [IDX_W-1:0]    idx_q;
   logic [6:0]          seg_q, dec_seg;
   logic [DIGITS-1:0]   en_q;
   logic [3:0]          codes [DIGITS];
   logic [3:0]          dec_in;
   logic                zero_above;
   logic                terminal;

   bcd_shift_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_Start (conv_start),
      .i_Value (bus.i_Value),
      .o_Busy  (conv_busy),
      .o_Done  (conv_done),
      .o_Bcd   (conv_bcd)
   );

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      conv_start = 1'b0;
      commit     = 1'b0;
      case (state_q)
         S_IDLE: if (bus.i_Load) begin
            conv_start = 1'b1;
            state_d    = S_CONVERT;
         end
         S_CONVERT: if (conv_done) state_d = S_COMMIT;
         S_COMMIT: begin
            commit  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ovf_pend_q <= 1'b0;
         ovf_q      <= 1'b0;
         disp_q     <= '0;
      end else begin
         if (conv_start) ovf_pend_q <= (32'(bus.i_Value) >= pow10(DIGITS));
         if (commit) begin
            ovf_q  <= ovf_pend_q;
            disp_q <= ovf_pend_q ? {DIGITS{4'd9}} : conv_bcd;
         end
      end
   end

   // A digit above 0 is blanked only when it and every digit above it are zero.
   always_comb begin
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above && (disp_q[4*k +: 4] == 4'd0);
         codes[k]   = ((BLANK_LEADING != 0) && (k != 0) && zero_above) ? BCD_BLANK : disp_q[4*k +: 4];
      end
      dec_in = codes[idx_q];
   end

   SegmentDisplay u_seg (.i_Binary_Num(dec_in), .o_Segment(dec_seg));

   assign terminal = (presc_q == PRESC_W'(SCAN_DIV - 1));

   // The output register blanks everything in the slot's first cycle as a ghosting guard.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_BLANK;
         en_q    <= '1;
      end else begin
         if (terminal) begin
            presc_q <= '0;
            idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            seg_q   <= SEG_BLANK;
            en_q    <= '1;
         end else begin
            presc_q <= presc_q + 1'b1;
            seg_q   <= dec_seg;
            en_q    <= ~(DIGITS'(1) << idx_q);
         end
      end
   end

   assign bus.o_Busy     = (state_q != S_IDLE) || conv_busy;
   assign bus.o_Overflow = ovf_q;
   assign bus.o_Segment  = seg_q;
   assign bus.o_Digit_En = en_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - scoreboard bench for seg_scan_controller
module tb_seg_scan_controller;
   localparam int DIGITS   = 2;
   localparam int BIN_W    = 7;
   localparam int SCAN_DIV = 4;

   typedef struct {
      int         dig;
      logic [6:0] seg;
      logic       ovf;
   } exp_t;

   logic i_Clk = 1'b0;
   logic i_Rst_n;
   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   seg_scan_controller_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) ifc ();

   seg_scan_controller #(
      .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .bus     (ifc.slave)
   );

   always #5 i_Clk = ~i_Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic int ipow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return t[d];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Reference: shown value is the input, or all nines on overflow; decimal digits by division.
   task automatic push_expect(input int v);
      int   lim, shown, d;
      exp_t e;
      lim   = ipow10(DIGITS);
      shown = (v >= lim) ? lim - 1 : v;
      for (int k = 0; k < DIGITS; k++) begin
         d     = (shown / ipow10(k)) % 10;
         e.dig = k;
         e.ovf = (v >= lim);
         e.seg = (k > 0 && shown < ipow10(k)) ? 7'b1111111 : seg_of(d);
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 100) begin
         @(negedge i_Clk);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d expectations pending, expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic do_load(input int v, input int ignored);
      int n;
      @(negedge i_Clk);
      ifc.i_Value = BIN_W'(v);
      ifc.i_Load  = 1'b1;
      @(negedge i_Clk);
      ifc.i_Load = 1'b0;
      n = 0;
      while (ifc.o_Busy && n < 50) begin
         n++;
         if (ignored >= 0 && n == 3) begin
            ifc.i_Value = BIN_W'(ignored);
            ifc.i_Load  = 1'b1;
         end else begin
            ifc.i_Load = 1'b0;
         end
         @(negedge i_Clk);
      end
      ifc.i_Load = 1'b0;
      chk($sformatf("busy_cycles(%0d)", v), n, BIN_W + 1);
      @(negedge i_Clk);
      push_expect(v);
      drain();
   endtask

   // Monitor: enforce the dead cycle between slots and score each lit digit against the queue.
   logic [DIGITS-1:0] prev_en = '1;
   always @(negedge i_Clk) begin
      logic [DIGITS-1:0] want;
      exp_t e;
      if (i_Rst_n) begin
         if (ifc.o_Digit_En != prev_en) begin
            checks++;
            if ((prev_en != '1 && ifc.o_Digit_En != '1) || $countones(~ifc.o_Digit_En) > 1) begin
               errors++;
               $display("FAIL dead_time: enable went %b -> %b, expected an all-ones cycle between", prev_en, ifc.o_Digit_En);
            end
         end
         prev_en = ifc.o_Digit_En;
         if (q.size() > 0) begin
            want = ~(DIGITS'(1) << q[0].dig);
            if (ifc.o_Digit_En == want) begin
               e = q.pop_front();
               checks++;
               if (ifc.o_Segment !== e.seg || ifc.o_Overflow !== e.ovf) begin
                  errors++;
                  $display("FAIL digit%0d: seg=%b ovf=%b, expected seg=%b ovf=%b",
                           e.dig, ifc.o_Segment, ifc.o_Overflow, e.seg, e.ovf);
               end
            end
         end
      end else begin
         prev_en = '1;
      end
   end

   initial begin
      int n;
      i_Rst_n     = 1'b0;
      ifc.i_Load  = 1'b0;
      ifc.i_Value = '0;
      repeat (5) @(negedge i_Clk);
      chk("reset_segment", ifc.o_Segment, 7'b1111111);
      chk("reset_digit_en", ifc.o_Digit_En, 2'b11);
      chk("reset_busy", ifc.o_Busy, 1'b0);
      chk("reset_overflow", ifc.o_Overflow, 1'b0);
      i_Rst_n = 1'b1;
      push_expect(0);
      drain();

      do_load(42, -1);
      do_load(7, -1);
      do_load(0, -1);
      do_load(127, -1);
      chk("overflow_127", ifc.o_Overflow, 1'b1);
      do_load(5, -1);
      chk("overflow_cleared", ifc.o_Overflow, 1'b0);
      do_load(42, 99);
      for (int i = 0; i < 12; i++) do_load(int'($urandom_range(0, 127)), -1);
      do_load(127, -1);

      // Reset in the middle of a conversion.
      @(negedge i_Clk);
      ifc.i_Value = 7'd42;
      ifc.i_Load  = 1'b1;
      @(posedge i_Clk);
      ifc.i_Load = 1'b0;
      repeat (4) @(posedge i_Clk);
      #2 i_Rst_n = 1'b0;
      #1;
      chk("async_reset_segment", ifc.o_Segment, 7'b1111111);
      chk("async_reset_digit_en", ifc.o_Digit_En, 2'b11);
      chk("async_reset_busy", ifc.o_Busy, 1'b0);
      chk("async_reset_overflow", ifc.o_Overflow, 1'b0);
      repeat (3) @(negedge i_Clk);
      i_Rst_n = 1'b1;
      n = 0;
      while (ifc.o_Digit_En == 2'b11 && n < 20) begin
         @(negedge i_Clk);
         n++;
      end
      chk("scan_restart_digit0", ifc.o_Digit_En, 2'b10);
      push_expect(0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Sequences a time-multiplexed multi-digit seven-segment display from a single binary value. Accepts a binary load, converts it to BCD with a sequential shift-add-3 engine, then scans the digits through one shared instance of the `SegmentDisplay` decoder. It drives the common digit enables. It sits between game/score logic and the board's display pins.

## Interface
- `DIGITS`, 2: number of display digits (1–4).
- `BIN_W`, 7: width of the binary input value.
- `SCAN_DIV`, 25000: clock cycles per digit slot; minimum 2.
- `BLANK_LEADING`, 1: when 1, leading zeros are blanked. Digit 0 is never blanked.
- `i_Clk`  in  1  system clock; the only clock.
- `i_Rst_n`  in  1  asynchronous, active-low reset.
- `i_Value`  in  BIN_W  binary value to display; sampled on accept.
- `i_Load`  in  1  load request; accepted when `o_Busy`=0.
- `o_Busy`  out  1  high while a conversion is in progress; loads are ignored while it is high.
- `o_Overflow`  out  1  latched high when the last accepted value was ≥ 10^DIGITS.
- `o_Segment`  out  7  active-low segments for the currently enabled digit; all-ones means blank.
- `o_Digit_En`  out  DIGITS  active-low digit enables; at most one bit low at any time.

## Operation
- **Reset values:**
  - `o_Busy`=0, `o_Overflow`=0.
  - `o_Segment`=7'b1111111, `o_Digit_En`=all ones.
  - Display register = all digits 0, which shows "0" in digit 0 only when `BLANK_LEADING`=1.
  - Scan index = 0, prescaler = 0.
- **FSM states:** IDLE, CONVERT, COMMIT.
  - IDLE → CONVERT when `i_Load`=1. Latch `i_Value` into the shift register and clear the BCD accumulator. Compute overflow as `i_Value` ≥ 10^DIGITS.
  - CONVERT: runs exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble that is ≥5, then shift {BCD, bin} left by 1. Then go to COMMIT.
  - COMMIT: runs 1 cycle. Write the display register atomically and update `o_Overflow`, then return to IDLE.
  - On overflow, the display register is loaded with all 9s instead of the converted BCD.
- **Handshake:**
  - `i_Load` is a level request, sampled only in IDLE.
  - `i_Load` held high re-triggers a new conversion on every IDLE cycle.
  - Loads in CONVERT/COMMIT are dropped, not queued.
- **Leading blank:**
  - Digit k > 0 is blank when it and all higher digits are 0.
  - A blanked digit presents code 4'hF to the decoder; the decoder's default case yields blank.
- **Scan:**
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - At the terminal count, the scan index advances and wraps from DIGITS-1 to 0.
  - Scanning runs continuously and is independent of the FSM. A COMMIT never restarts the scan.
- **Dead time:** on the cycle after an index change, `o_Digit_En` is all ones (ghosting guard). From the next cycle, the new digit is enabled with its segments.

## Timing
- Accept on cycle 0 (IDLE with `i_Load`=1):
  - `o_Busy`=1 from cycle 1 through cycle BIN_W+1.
  - Display register and `o_Overflow` are valid from cycle BIN_W+2.
  - `o_Busy`=0 at cycle BIN_W+2; a new load can be accepted there.
- `o_Segment` and `o_Digit_En` are both registered and change on the same edge.
  - Decoder-input-to-`o_Segment` latency: 1 cycle.
- Digit slot: 1 dead cycle followed by SCAN_DIV-1 lit cycles. Full frame = DIGITS×SCAN_DIV cycles.
- A COMMIT landing mid-slot updates the segments of the currently lit digit on the next cycle. There is no enable glitch.
- Reset asserted mid-conversion:
  - All state returns to reset values immediately (asynchronously).
  - The partial result is discarded and the previous display register is lost.

## Structure
- Shared package `display_pkg`:
  - FSM state typedef.
  - `SEG_BLANK` = 7'b1111111.
  - `BCD_BLANK` = 4'hF.
  - 10^DIGITS limit function.
- Sub-module `bcd_shift_converter` (BIN_W, DIGITS): start/busy/done interface, holds the shift-add-3 datapath. The controller keeps the FSM, scan and output registers.
- One `SegmentDisplay` instance, fed by the scan-index mux.

## Test plan
- **Reset:** hold `i_Rst_n`=0 for 5 cycles, then release.
  - Required during reset: `o_Segment`=1111111, `o_Digit_En`=11, `o_Busy`=0.
  - Required after release: digit 0 shows 1000000 and digit 1 is blank.
- **Load 42** (SCAN_DIV=4):
  - `o_Busy` is high for exactly 8 cycles.
  - Then digit 0 (`o_Digit_En`=10) shows 0100100 and digit 1 (01) shows 0011001.
  - Exactly one all-off cycle separates the two slots.
- **Load 7:** digit 1 is blank (1111111) and digit 0 shows 1111000. **Load 0:** digit 0 shows 1000000.
- **Load 127:** `o_Overflow`=1 and both digits show 0010000. A following load of 5 clears `o_Overflow`.
- **Load 42, then load 99 on cycle 3 while busy:** the second load is ignored and the display shows 42.
- **Reset mid-conversion:** load 42, assert `i_Rst_n` low on cycle 4.
  - Outputs go to reset values asynchronously.
  - After release, the display shows 0 and the scan restarts at digit 0.
